// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared widths and FSM state encoding for the IN-instruction
//            operator input path.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int LARGURA_DADO   = 32;
    localparam int LARGURA_CHAVES = 4;

    typedef enum logic [2:0] {
        OCIOSO        = 3'd0,
        ESPERA_SOLTO  = 3'd1,
        ESPERA_APERTO = 3'd2,
        ENTREGA       = 3'd3,
        ESPERA_FIM    = 3'd4
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/debounce_botao.sv
`default_nettype none
// ============================================================================
// Module   : debounce_botao
// Purpose  : Two-flop synchronizer, polarity normalisation and stable-count
//            debouncer for the board key; apertado_d is active-high.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_botao #(
    parameter int   DEBOUNCE_CICLOS = 500000,
    parameter logic NIVEL_APERTADO  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic botaoPlaca,
    output logic apertado_d
);

    localparam int c_largura = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [c_largura-1:0] c_limite = c_largura'(DEBOUNCE_CICLOS - 1);

    logic [1:0]           r_sinc;
    logic                 w_apertado_s;
    logic                 r_apertado_d;
    logic [c_largura-1:0] r_contador;

    // Synchronizer idles at the released level so reset never looks like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sinc <= {2{~NIVEL_APERTADO}};
        end else begin
            r_sinc <= {r_sinc[0], botaoPlaca};
        end
    end

    assign w_apertado_s = (r_sinc[1] == NIVEL_APERTADO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_apertado_d <= 1'b0;
            r_contador   <= '0;
        end else if (w_apertado_s == r_apertado_d) begin
            r_contador   <= '0;
        end else if (r_contador == c_limite) begin
            r_apertado_d <= w_apertado_s;
            r_contador   <= '0;
        end else begin
            r_contador   <= r_contador + 1'b1;
        end
    end

    assign apertado_d = r_apertado_d;

endmodule
`default_nettype wire

// File: rtl/entrada_botao_handshake.sv
`default_nettype none
// ============================================================================
// Module   : entrada_botao_handshake
// Purpose  : IN-instruction responder: stalls the CPU until a debounced key
//            press, then returns the switches zero-extended with a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module entrada_botao_handshake
    import io_pkg::*;
#(
    parameter int   DEBOUNCE_CICLOS = 500000,
    parameter logic NIVEL_APERTADO  = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      comandoIN,
    input  logic                      botaoPlaca,
    input  logic [LARGURA_CHAVES-1:0] entradaDeDadosIO,
    output logic [LARGURA_DADO-1:0]   dadosEntrada,
    output logic                      dadoValido,
    output logic                      parada,
    output logic                      ledin
);

    logic [1:0]                r_rst_sinc;
    logic                      w_liberado;
    logic [LARGURA_CHAVES-1:0] r_chaves_meta;
    logic [LARGURA_CHAVES-1:0] r_chaves_sinc;
    logic                      w_apertado_d;
    estado_t                   r_estado;
    estado_t                   w_proximo;
    logic                      w_captura;
    logic [LARGURA_DADO-1:0]   r_dados;
    logic                      w_parada;

    // Reset asserts asynchronously but is released through two flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rst_sinc <= 2'b11;
        end else begin
            r_rst_sinc <= {r_rst_sinc[0], 1'b0};
        end
    end

    assign w_liberado = ~r_rst_sinc[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_chaves_meta <= '0;
            r_chaves_sinc <= '0;
        end else begin
            r_chaves_meta <= entradaDeDadosIO;
            r_chaves_sinc <= r_chaves_meta;
        end
    end

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .NIVEL_APERTADO  (NIVEL_APERTADO)
    ) u_debounce (
        .clock      (clock),
        .reset      (reset),
        .botaoPlaca (botaoPlaca),
        .apertado_d (w_apertado_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        w_captura = 1'b0;
        if (!w_liberado) begin
            w_proximo = OCIOSO;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (comandoIN) w_proximo = ESPERA_SOLTO;
                end
                // Abort takes priority so a dropped command never captures.
                ESPERA_SOLTO: begin
                    if (!comandoIN)        w_proximo = OCIOSO;
                    else if (!w_apertado_d) w_proximo = ESPERA_APERTO;
                end
                ESPERA_APERTO: begin
                    if (!comandoIN) begin
                        w_proximo = OCIOSO;
                    end else if (w_apertado_d) begin
                        w_captura = 1'b1;
                        w_proximo = ENTREGA;
                    end
                end
                ENTREGA: begin
                    w_proximo = ESPERA_FIM;
                end
                ESPERA_FIM: begin
                    if (!comandoIN) w_proximo = OCIOSO;
                end
                default: begin
                    w_proximo = OCIOSO;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dados <= '0;
        end else if (w_captura) begin
            r_dados <= {{(LARGURA_DADO-LARGURA_CHAVES){1'b0}}, r_chaves_sinc};
        end
    end

    assign w_parada     = (r_estado == ESPERA_SOLTO) || (r_estado == ESPERA_APERTO);
    assign dadosEntrada = r_dados;
    assign dadoValido   = (r_estado == ENTREGA);
    assign parada       = w_parada;
    assign ledin        = w_parada;

endmodule
`default_nettype wire

// File: tb/tb_entrada_botao_handshake.sv
`default_nettype none
// ============================================================================
// Module   : tb_entrada_botao_handshake
// Purpose  : Directed self-checking bench for entrada_botao_handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entrada_botao_handshake;

    localparam int c_debounce = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        comandoIN;
    logic        botaoPlaca;
    logic [3:0]  entradaDeDadosIO;
    logic [31:0] dadosEntrada;
    logic        dadoValido;
    logic        parada;
    logic        ledin;

    int          n_total = 0;
    int          n_ok    = 0;
    int          n0;
    logic [31:0] strobes[$];

    always #5 clock = ~clock;

    entrada_botao_handshake #(
        .DEBOUNCE_CICLOS (c_debounce),
        .NIVEL_APERTADO  (1'b0)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .comandoIN        (comandoIN),
        .botaoPlaca       (botaoPlaca),
        .entradaDeDadosIO (entradaDeDadosIO),
        .dadosEntrada     (dadosEntrada),
        .dadoValido       (dadoValido),
        .parada           (parada),
        .ledin            (ledin)
    );

    // Every strobe cycle is logged with the data presented alongside it.
    always @(negedge clock) begin
        if (dadoValido === 1'b1) strobes.push_back(dadosEntrada);
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
    endtask

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic espera_strobe(input string tag, input int limite);
        logic achou;
        achou = 1'b0;
        for (int i = 0; i < limite; i++) begin
            ciclos(1);
            if (dadoValido === 1'b1) begin
                achou = 1'b1;
                break;
            end
        end
        verifica(tag, {31'b0, achou}, 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        comandoIN        = 1'b0;
        botaoPlaca       = 1'b1;
        entradaDeDadosIO = 4'h0;
        ciclos(3);
        verifica("rst_dados",  dadosEntrada, 32'h0);
        verifica("rst_valido", {31'b0, dadoValido}, 32'd0);
        verifica("rst_parada", {31'b0, parada}, 32'd0);
        verifica("rst_ledin",  {31'b0, ledin}, 32'd0);
        reset = 1'b0;
        ciclos(4);

        // Reset while stalled
        comandoIN = 1'b1;
        ciclos(1);
        verifica("espera_parada", {31'b0, parada}, 32'd1);
        ciclos(2);
        reset = 1'b1;
        #1;
        verifica("rst_meio_parada", {31'b0, parada}, 32'd0);
        verifica("rst_meio_ledin",  {31'b0, ledin}, 32'd0);
        verifica("rst_meio_valido", {31'b0, dadoValido}, 32'd0);
        comandoIN = 1'b0;
        ciclos(2);
        reset = 1'b0;
        n0 = strobes.size();
        ciclos(10);
        verifica("rst_meio_sem_strobe", strobes.size() - n0, 32'd0);

        // Basic IN with exact press latency
        entradaDeDadosIO = 4'hA;
        comandoIN = 1'b1;
        ciclos(1);
        verifica("basico_parada_sobe", {31'b0, parada}, 32'd1);
        ciclos(3);
        n0 = strobes.size();
        botaoPlaca = 1'b0;
        ciclos(6);
        verifica("basico_valido_cedo", {31'b0, dadoValido}, 32'd0);
        verifica("basico_parada_cedo", {31'b0, parada}, 32'd1);
        ciclos(1);
        verifica("basico_valido", {31'b0, dadoValido}, 32'd1);
        verifica("basico_dados",  dadosEntrada, 32'h0000000A);
        verifica("basico_parada", {31'b0, parada}, 32'd0);
        verifica("basico_ledin",  {31'b0, ledin}, 32'd0);
        entradaDeDadosIO = 4'h5;
        ciclos(1);
        verifica("basico_valido_cai", {31'b0, dadoValido}, 32'd0);
        ciclos(3);
        verifica("basico_dados_retido", dadosEntrada, 32'h0000000A);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b1;
        ciclos(12);
        verifica("basico_um_strobe", strobes.size() - n0, 32'd1);

        // Abort in ESPERA_APERTO
        n0 = strobes.size();
        comandoIN = 1'b1;
        ciclos(3);
        verifica("abort_parada_antes", {31'b0, parada}, 32'd1);
        comandoIN = 1'b0;
        ciclos(1);
        verifica("abort_parada_cai", {31'b0, parada}, 32'd0);
        botaoPlaca = 1'b0;
        ciclos(12);
        verifica("abort_sem_strobe", strobes.size() - n0, 32'd0);
        verifica("abort_dados", dadosEntrada, 32'h0000000A);
        botaoPlaca = 1'b1;
        ciclos(12);

        // Bounce shorter than the debounce window
        n0 = strobes.size();
        entradaDeDadosIO = 4'h3;
        comandoIN = 1'b1;
        ciclos(3);
        botaoPlaca = 1'b0;
        ciclos(3);
        botaoPlaca = 1'b1;
        ciclos(12);
        verifica("quique_sem_strobe", strobes.size() - n0, 32'd0);
        verifica("quique_parada", {31'b0, parada}, 32'd1);
        botaoPlaca = 1'b0;
        espera_strobe("quique_strobe_limpo", 20);
        verifica("quique_dados", dadosEntrada, 32'h00000003);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b1;
        ciclos(12);

        // Key already held when the command arrives
        botaoPlaca = 1'b0;
        ciclos(12);
        entradaDeDadosIO = 4'h6;
        n0 = strobes.size();
        comandoIN = 1'b1;
        ciclos(15);
        verifica("segurado_sem_strobe", strobes.size() - n0, 32'd0);
        verifica("segurado_parada", {31'b0, parada}, 32'd1);
        botaoPlaca = 1'b1;
        ciclos(8);
        botaoPlaca = 1'b0;
        espera_strobe("segurado_strobe", 20);
        verifica("segurado_dados", dadosEntrada, 32'h00000006);
        ciclos(15);
        verifica("segurado_um_strobe", strobes.size() - n0, 32'd1);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b1;
        ciclos(12);

        // Back-to-back commands separated by one low cycle
        n0 = strobes.size();
        entradaDeDadosIO = 4'h1;
        comandoIN = 1'b1;
        ciclos(3);
        botaoPlaca = 1'b0;
        espera_strobe("b2b_strobe_1", 20);
        botaoPlaca = 1'b1;
        ciclos(1);
        comandoIN = 1'b0;
        ciclos(1);
        comandoIN = 1'b1;
        entradaDeDadosIO = 4'hF;
        ciclos(12);
        botaoPlaca = 1'b0;
        espera_strobe("b2b_strobe_2", 20);
        comandoIN  = 1'b0;
        botaoPlaca = 1'b1;
        ciclos(12);
        verifica("b2b_contagem", strobes.size() - n0, 32'd2);
        verifica("b2b_valor_1", (strobes.size() > n0)     ? strobes[n0]     : 32'hDEAD_BEEF, 32'h00000001);
        verifica("b2b_valor_2", (strobes.size() > n0 + 1) ? strobes[n0 + 1] : 32'hDEAD_BEEF, 32'h0000000F);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
`default_nettype wire
